// File: rtl/sink_pkg.sv
// ============================================================================
// Module      : sink_pkg
// Description : Shared definitions for the sink request engine: power-state
//               encoding and request-packet field offsets. The request packet
//               is laid out as {rd0_wr1, valid, addr, data}, data at bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sink_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    DRAIN  = 2'b01,
    IDLE   = 2'b11
  } sink_state_e;

  function automatic int addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int valid_pos(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int dir_pos(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sink_outst_tracker.sv
// ============================================================================
// Module      : sink_outst_tracker
// Description : Outstanding-read counter with an optional read watchdog.
//               Build macro SINK_TIMEOUT_EN enables the watchdog, which
//               retires the oldest read as an error after TIMEOUT_CYCLES.
// Ports       : i_clk_sink/i_rst_sink - clock, async active-high reset
//               i_rd_issue            - a read is issued this cycle
//               i_rd_valid            - master read data valid
//               o_outstanding         - reads in flight
//               o_accept              - rd_valid matched an outstanding read
//               o_timeout             - watchdog retires a read this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sink_outst_tracker #(
  parameter  int MAX_OUTST      = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int CNT_W          = $clog2(MAX_OUTST + 1)
) (
  input  logic             i_clk_sink,
  input  logic             i_rst_sink,
  input  logic             i_rd_issue,
  input  logic             i_rd_valid,
  output logic [CNT_W-1:0] o_outstanding,
  output logic             o_accept,
  output logic             o_timeout
);

  logic [CNT_W-1:0] r_outst;
  logic             w_dec;

  // Data with nothing in flight is not ours to forward.
  assign o_accept = i_rd_valid && (r_outst != '0) && !i_rst_sink;

`ifdef SINK_TIMEOUT_EN
  localparam int                c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

  logic [c_wd_w-1:0] r_wd;

  // A real response in the same cycle wins over the timeout.
  assign o_timeout = (r_outst != '0) && (r_wd == c_wd_last) && !o_accept && !i_rst_sink;

  always_ff @(posedge i_clk_sink or posedge i_rst_sink) begin
    if (i_rst_sink) begin
      r_wd <= '0;
    end else if (o_accept || o_timeout || (r_outst == '0)) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign o_timeout        = 1'b0;
`endif

  assign w_dec = o_accept || o_timeout;

  // Issue and retire in the same cycle cancel out.
  always_ff @(posedge i_clk_sink or posedge i_rst_sink) begin
    if (i_rst_sink) begin
      r_outst <= '0;
    end else if (i_rd_issue && !w_dec) begin
      r_outst <= r_outst + 1'b1;
    end else if (!i_rd_issue && w_dec) begin
      r_outst <= r_outst - 1'b1;
    end
  end

  assign o_outstanding = r_outst;

endmodule

`default_nettype wire

// File: rtl/sink_req_engine.sv
// ============================================================================
// Module      : sink_req_engine
// Description : Sink-side request engine. Pops requests from a request FIFO,
//               issues them to a master port, tracks outstanding reads,
//               pushes read responses and handles sleep/drain handshakes.
//               Build macro SINK_TIMEOUT_EN adds a read watchdog and an error
//               bit on top of the response packet.
// Ports       : i_clk_sink/i_rst_sink  - clock, async active-high reset
//               i_sink_sleep_req       - local sleep request
//               i_source_sleep_status  - source domain asleep
//               i_packet/i_req_fifo_empty/o_req_fifo_rd_en - request FIFO
//               o_packet/o_rsp_fifo_wr_en/i_rsp_fifo_empty/i_rsp_fifo_free
//                                      - response FIFO
//               o_valid/o_rd0_wr1/o_addr/o_wr_data/i_ready/i_rd_data/
//               i_rd_valid             - master port
//               o_sink_sleep_ack/o_sink_sleep_status/o_reset_flag - power
//               o_outstanding/o_drop_count/o_spurious - status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sink_req_engine
  import sink_pkg::*;
#(
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int MAX_OUTST      = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int PKT_W          = ADDR_WIDTH + DATA_WIDTH + 2,
`ifdef SINK_TIMEOUT_EN
  localparam int RSP_W          = DATA_WIDTH + 2,
`else
  localparam int RSP_W          = DATA_WIDTH + 1,
`endif
  localparam int CNT_W          = $clog2(MAX_OUTST + 1)
) (
  input  logic                  i_clk_sink,
  input  logic                  i_rst_sink,
  input  logic                  i_sink_sleep_req,
  input  logic                  i_source_sleep_status,
  input  logic [PKT_W-1:0]      i_packet,
  input  logic                  i_req_fifo_empty,
  input  logic                  i_rsp_fifo_empty,
  input  logic [CNT_W-1:0]      i_rsp_fifo_free,
  input  logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic                  i_rd_valid,
  output logic                  o_rd0_wr1,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_valid,
  output logic                  o_req_fifo_rd_en,
  output logic                  o_rsp_fifo_wr_en,
  output logic [RSP_W-1:0]      o_packet,
  output logic                  o_sink_sleep_ack,
  output logic                  o_sink_sleep_status,
  output logic                  o_reset_flag,
  output logic [CNT_W-1:0]      o_outstanding,
  output logic [7:0]            o_drop_count,
  output logic                  o_spurious
);

  localparam int               c_addr_lsb  = addr_lsb(DATA_WIDTH);
  localparam int               c_valid_pos = valid_pos(ADDR_WIDTH, DATA_WIDTH);
  localparam int               c_dir_pos   = dir_pos(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_max_outst = CNT_W'(MAX_OUTST);

  sink_state_e      r_state;
  logic [7:0]       r_drop;
  logic [CNT_W-1:0] w_outst;
  logic             w_active;
  logic             w_head_live;
  logic             w_head_valid;
  logic             w_head_wr;
  logic             w_rd_room;
  logic             w_issue;
  logic             w_drop;
  logic             w_accept;
  logic             w_timeout;
  logic             w_push;

  // Reset masks every combinational action so nothing leaks out while held.
  assign w_active     = ((r_state == NORMAL) || (r_state == DRAIN)) && !i_rst_sink;
  assign w_head_live  = w_active && !i_req_fifo_empty;
  assign w_head_valid = i_packet[c_valid_pos];
  assign w_head_wr    = i_packet[c_dir_pos];
  // A read needs both a tracking slot and a guaranteed response FIFO slot.
  assign w_rd_room    = (w_outst < c_max_outst) && (w_outst < i_rsp_fifo_free);
  assign w_issue      = w_head_live && w_head_valid && i_ready && (w_head_wr || w_rd_room);
  assign w_drop       = w_head_live && !w_head_valid;

  assign o_valid          = w_issue;
  assign o_rd0_wr1        = w_issue && w_head_wr;
  assign o_addr           = w_issue ? i_packet[c_addr_lsb +: ADDR_WIDTH] : '0;
  assign o_wr_data        = w_issue ? i_packet[DATA_WIDTH-1:0] : '0;
  assign o_req_fifo_rd_en = w_issue || w_drop;

  sink_outst_tracker #(
    .MAX_OUTST      (MAX_OUTST),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tracker (
    .i_clk_sink    (i_clk_sink),
    .i_rst_sink    (i_rst_sink),
    .i_rd_issue    (w_issue && !w_head_wr),
    .i_rd_valid    (i_rd_valid),
    .o_outstanding (w_outst),
    .o_accept      (w_accept),
    .o_timeout     (w_timeout)
  );

  assign w_push           = w_accept || w_timeout;
  assign o_rsp_fifo_wr_en = w_push;
  assign o_outstanding    = w_outst;
  assign o_spurious       = i_rd_valid && (w_outst == '0) && !i_rst_sink;

`ifdef SINK_TIMEOUT_EN
  logic [DATA_WIDTH-1:0] w_rsp_data;
  assign w_rsp_data = w_timeout ? '0 : i_rd_data;
  assign o_packet   = w_push ? {w_timeout, 1'b1, w_rsp_data} : '0;
`else
  assign o_packet   = w_push ? {1'b1, i_rd_data} : '0;
`endif

  always_ff @(posedge i_clk_sink or posedge i_rst_sink) begin
    if (i_rst_sink) begin
      r_state <= NORMAL;
    end else begin
      case (r_state)
        NORMAL: if (i_sink_sleep_req || i_source_sleep_status) r_state <= DRAIN;
        DRAIN:  if (i_req_fifo_empty && (w_outst == '0) && i_rsp_fifo_empty) r_state <= IDLE;
        IDLE:   if (!i_sink_sleep_req && !i_source_sleep_status) r_state <= NORMAL;
        default: r_state <= NORMAL;
      endcase
    end
  end

  always_ff @(posedge i_clk_sink or posedge i_rst_sink) begin
    if (i_rst_sink) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign o_drop_count        = r_drop;
  assign o_sink_sleep_status = (r_state == IDLE);
  // Active-low: ask for a domain reset only once asleep with the source down.
  assign o_reset_flag        = !((r_state == IDLE) && i_source_sleep_status);
  assign o_sink_sleep_ack    = (r_state == IDLE) ? (i_sink_sleep_req && !i_source_sleep_status)
                                                 : i_sink_sleep_req;

endmodule

`default_nettype wire
